// File: rtl/scandubclk_ce_gen.sv
// scandubclk_ce_gen: multi-channel fractional clock-enable generator, ce[i] density inc/den.
// Define SCANDUBCLK_CE_PHASE_EN to add a per-channel phase offset (cfg_phase) on reload.
module scandubclk_ce_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned RST_INC     = 16,
  parameter int unsigned RST_DEN     = 25,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_den,
`ifdef SCANDUBCLK_CE_PHASE_EN
  input  logic [ACC_W-1:0]  cfg_phase,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam int unsigned      CNT_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LockMax = CNT_W'(LOCK_CYCLES);
  localparam logic [ACC_W-1:0] RstInc  = ACC_W'(RST_INC);
  localparam logic [ACC_W-1:0] RstDen  = ACC_W'(RST_DEN);
  localparam logic [CH_W:0]    NumChL  = (CH_W + 1)'(NUM_CH);

  typedef enum logic {StRun, StPend} ch_st_e;

  logic              cfg_ok;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] pend_vec;
  logic [NUM_CH-1:0] ce_d;

  assign cfg_ok = (cfg_den != '0) && ({1'b0, cfg_ch} < NumChL);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_st_e           st_q, st_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic [ACC_W-1:0] stg_inc_q, stg_inc_d;
    logic [ACC_W-1:0] stg_den_q, stg_den_d;
    logic [ACC_W-1:0] eff_inc;
    logic [ACC_W-1:0] reload;
    logic [ACC_W:0]   sum;
    logic             wrap;
    logic             wr_hit;

    // Saturating inc at den keeps acc < den and gives ce every cycle.
    assign eff_inc     = (inc_q >= den_q) ? den_q : inc_q;
    assign sum         = {1'b0, acc_q} + {1'b0, eff_inc};
    assign wrap        = (sum >= {1'b0, den_q});
    assign wr_hit      = cfg_wr && cfg_ok && (cfg_ch == CH_W'(i));
    assign apply[i]    = en && (st_q == StPend) && (sync || wrap || (inc_q == '0));
    assign pend_vec[i] = (st_q == StPend);
    assign ce_d[i]     = en && !sync && wrap;

`ifdef SCANDUBCLK_CE_PHASE_EN
    logic [ACC_W-1:0] ph_q, ph_d;
    logic [ACC_W-1:0] stg_ph_q, stg_ph_d;
    logic [ACC_W-1:0] rl_ph, rl_den;

    assign rl_ph  = apply[i] ? stg_ph_q : ph_q;
    assign rl_den = apply[i] ? stg_den_q : den_q;
    assign reload = (rl_ph >= rl_den) ? (rl_den - 1'b1) : rl_ph;
`else
    assign reload = '0;
`endif

    always_comb begin
      st_d      = st_q;
      acc_d     = acc_q;
      inc_d     = inc_q;
      den_d     = den_q;
      stg_inc_d = stg_inc_q;
      stg_den_d = stg_den_q;
`ifdef SCANDUBCLK_CE_PHASE_EN
      ph_d      = ph_q;
      stg_ph_d  = stg_ph_q;
`endif
      if (apply[i]) begin
        inc_d = stg_inc_q;
        den_d = stg_den_q;
        acc_d = reload;
        st_d  = StRun;
`ifdef SCANDUBCLK_CE_PHASE_EN
        ph_d  = stg_ph_q;
`endif
      end else if (en && sync) begin
        acc_d = reload;
      end else if (en && wrap) begin
        // True result is below den, so modular ACC_W arithmetic is exact.
        acc_d = acc_q + eff_inc - den_q;
      end else if (en) begin
        acc_d = acc_q + eff_inc;
      end
      // A write in the same cycle as an apply stays staged for the next wrap.
      if (wr_hit) begin
        stg_inc_d = cfg_inc;
        stg_den_d = cfg_den;
        st_d      = StPend;
`ifdef SCANDUBCLK_CE_PHASE_EN
        stg_ph_d  = cfg_phase;
`endif
      end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        st_q      <= StRun;
        acc_q     <= '0;
        inc_q     <= RstInc;
        den_q     <= RstDen;
        stg_inc_q <= '0;
        stg_den_q <= '0;
`ifdef SCANDUBCLK_CE_PHASE_EN
        ph_q      <= '0;
        stg_ph_q  <= '0;
`endif
      end else begin
        st_q      <= st_d;
        acc_q     <= acc_d;
        inc_q     <= inc_d;
        den_q     <= den_d;
        stg_inc_q <= stg_inc_d;
        stg_den_q <= stg_den_d;
`ifdef SCANDUBCLK_CE_PHASE_EN
        ph_q      <= ph_d;
        stg_ph_q  <= stg_ph_d;
`endif
      end
    end
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_clr;

  assign lock_clr = !en || (|apply) || (|pend_vec);

  always_comb begin
    cnt_d = cnt_q;
    if (lock_clr) begin
      cnt_d = '0;
    end else if (cnt_q != LockMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ce      <= '0;
      cfg_err <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ce      <= ce_d;
      cfg_err <= cfg_wr && !cfg_ok;
    end
  end

  assign locked = (cnt_q == LockMax);
  assign pend   = pend_vec;

endmodule
